pixel_ctx_dec: RTL and testbench

//  Decoder-side JPEG-LS neighbourhood generator, the counterpart of the encoder pixel/context

---
 rtl/pixel_ctx_dec_pkg.sv | 25 ++
 rtl/pixel_ctx_dec_if.sv | 40 ++++
 rtl/pixel_ctx_dec_line_buf.sv | 36 +++
 rtl/pixel_ctx_dec.sv | 171 +++++++++++++++++
 tb/tb_pixel_ctx_dec.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_ctx_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_ctx_pkg
// Description : Shared constants for the JPEG-LS decoder neighbourhood
//               generator: default geometry, counter width and FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_ctx_pkg;

    localparam int c_DW_DEFAULT      = 16;
    localparam int c_IMAGE_W_DEFAULT = 256;
    localparam int c_IMAGE_H_DEFAULT = 256;

    // Column and row counters are 10 bits wide (frames up to 1024 x 1024)
    localparam int c_CNT_W = 10;

    // Frame sequencer state encoding
    localparam int         c_ST_W = 2;
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_LOAD = 2'd1;
    localparam logic [1:0] c_S_CTX  = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pixel_ctx_dec_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_ctx_dec_if
// Description : Context / reconstructed-pixel loop between the neighbourhood
//               generator (master) and the decoding datapath (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_ctx_dec_if #(
    parameter int DW = 16
);
    logic          start;
    logic          ctx_valid;
    logic [DW-1:0] Ra;
    logic [DW-1:0] Rb;
    logic [DW-1:0] Rc;
    logic [DW-1:0] Rd;
    logic [DW:0]   D1;
    logic [DW:0]   D2;
    logic [DW:0]   D3;
    logic [9:0]    col;
    logic [9:0]    row;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] pix_out;
    logic          pix_out_en;
    logic          frame_done;

    modport master (
        input  start, rx_data, rx_valid,
        output ctx_valid, Ra, Rb, Rc, Rd, D1, D2, D3, col, row,
               pix_out, pix_out_en, frame_done
    );

    modport slave (
        output start, rx_data, rx_valid,
        input  ctx_valid, Ra, Rb, Rc, Rd, D1, D2, D3, col, row,
               pix_out, pix_out_en, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/pixel_ctx_dec_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : line_buf_ram
// Description : One-row line buffer. Register array with two combinational
//               read ports and one synchronous write port; no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buf_ram #(
    parameter int DEPTH = 256,
    parameter int DW    = 16,
    parameter int AW    = 8
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [DW-1:0] i_wdata,
    input  wire logic [AW-1:0] i_raddr_a,
    output      logic [DW-1:0] o_rdata_a,
    input  wire logic [AW-1:0] i_raddr_b,
    output      logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_mem [DEPTH];

    // Write the accepted pixel into its column slot
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/pixel_ctx_dec.sv
`default_nettype none
// ============================================================================
// Module      : pixel_ctx_dec
// Description : JPEG-LS decoder neighbourhood generator. Presents Ra..Rd and
//               gradients D1..D3 for the current raster position, accepts the
//               reconstructed pixel back and re-emits it as a raster stream.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_ctx_dec
    import pixel_ctx_pkg::*;
#(
    parameter int IMAGE_W = c_IMAGE_W_DEFAULT,
    parameter int IMAGE_H = c_IMAGE_H_DEFAULT,
    parameter int DW      = c_DW_DEFAULT
) (
    input wire logic        clk,
    input wire logic        rst,
    pixel_ctx_dec_if.master bus
);

    localparam int                 c_AW     = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
    localparam logic [c_CNT_W-1:0] c_W_LAST = c_CNT_W'(IMAGE_W - 1);
    localparam logic [c_CNT_W-1:0] c_H_LAST = c_CNT_W'(IMAGE_H - 1);
    localparam logic [c_CNT_W:0]   c_W_M1X  = (c_CNT_W + 1)'(IMAGE_W - 1);

    logic [c_ST_W-1:0]  r_state;
    logic [c_CNT_W-1:0] r_col;
    logic [c_CNT_W-1:0] r_row;
    logic [DW-1:0]      r_ra;
    logic [DW-1:0]      r_rb;
    logic [DW-1:0]      r_rc;
    logic [DW-1:0]      r_rd;
    logic [DW-1:0]      r_pix_out;
    logic               r_pix_out_en;
    logic               r_frame_done;

    logic               w_ctx_valid;
    logic               w_acc;
    logic [c_CNT_W:0]   w_col_p2;
    logic               w_past_edge;
    logic [c_AW-1:0]    w_raddr_a;
    logic [DW-1:0]      w_rdata_a;
    logic [DW-1:0]      w_buf0;
    logic [DW:0]        w_d1;
    logic [DW:0]        w_d2;
    logic [DW:0]        w_d3;

    assign w_ctx_valid = (r_state == c_S_CTX);
    assign w_acc       = w_ctx_valid & bus.rx_valid;

    // Look-ahead column for the above-right neighbour; beyond the right edge
    // the value is replicated from Rb instead of being read.
    assign w_col_p2    = {1'b0, r_col} + (c_CNT_W + 1)'(2);
    assign w_past_edge = (w_col_p2 > c_W_M1X);

    // Port A serves buf[1] while loading a row, buf[c+2] while streaming
    assign w_raddr_a = (r_state == c_S_LOAD) ? c_AW'(1)
                     : (w_past_edge ? '0 : w_col_p2[c_AW-1:0]);

    line_buf_ram #(
        .DEPTH (IMAGE_W),
        .DW    (DW),
        .AW    (c_AW)
    ) u_line_buf (
        .clk       (clk),
        .i_we      (w_acc),
        .i_waddr   (r_col[c_AW-1:0]),
        .i_wdata   (bus.rx_data),
        .i_raddr_a (w_raddr_a),
        .o_rdata_a (w_rdata_a),
        .i_raddr_b (c_AW'(0)),
        .o_rdata_b (w_buf0)
    );

    // Frame sequencer, raster counters, neighbour registers and output stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_ra         <= '0;
            r_rb         <= '0;
            r_rc         <= '0;
            r_rd         <= '0;
            r_pix_out    <= '0;
            r_pix_out_en <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_pix_out_en <= w_acc;
            r_frame_done <= (r_state == c_S_DONE);
            if (w_acc) begin
                r_pix_out <= bus.rx_data;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (bus.start) begin
                        r_state <= c_S_LOAD;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end

                c_S_LOAD: begin
                    // Row 0 has no history: the stale buffer is masked out
                    if (r_row == '0) begin
                        r_ra <= '0;
                        r_rb <= '0;
                        r_rc <= '0;
                        r_rd <= '0;
                    end else begin
                        r_ra <= w_buf0;
                        r_rb <= w_buf0;
                        r_rc <= w_buf0;
                        r_rd <= w_rdata_a;
                    end
                    r_state <= c_S_CTX;
                end

                c_S_CTX: begin
                    if (w_acc) begin
                        r_ra <= bus.rx_data;
                        r_rc <= r_rb;
                        r_rb <= r_rd;
                        if (r_row == '0) begin
                            r_rd <= '0;
                        end else if (!w_past_edge) begin
                            r_rd <= w_rdata_a;
                        end
                        if (r_col != c_W_LAST) begin
                            r_col <= r_col + c_CNT_W'(1);
                        end else if (r_row != c_H_LAST) begin
                            r_col   <= '0;
                            r_row   <= r_row + c_CNT_W'(1);
                            r_state <= c_S_LOAD;
                        end else begin
                            r_state <= c_S_DONE;
                        end
                    end
                end

                default: begin
                    r_col   <= '0;
                    r_row   <= '0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Gradients on zero-extended operands, wrapping modulo 2^(DW+1)
    assign w_d1 = {1'b0, r_rd} - {1'b0, r_rb};
    assign w_d2 = {1'b0, r_rb} - {1'b0, r_rc};
    assign w_d3 = {1'b0, r_rc} - {1'b0, r_ra};

    assign bus.ctx_valid  = w_ctx_valid;
    assign bus.Ra         = r_ra;
    assign bus.Rb         = r_rb;
    assign bus.Rc         = r_rc;
    assign bus.Rd         = r_rd;
    assign bus.D1         = w_ctx_valid ? w_d1 : '0;
    assign bus.D2         = w_ctx_valid ? w_d2 : '0;
    assign bus.D3         = w_ctx_valid ? w_d3 : '0;
    assign bus.col        = r_col;
    assign bus.row        = r_row;
    assign bus.pix_out    = r_pix_out;
    assign bus.pix_out_en = r_pix_out_en;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_ctx_dec.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_ctx_dec
// Description : Scoreboard bench for pixel_ctx_dec on a 4 x 3 frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_ctx_dec;

    typedef struct {
        logic [9:0]  row;
        logic [9:0]  col;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] rc;
        logic [15:0] rd;
        logic [16:0] d1;
        logic [16:0] d2;
        logic [16:0] d3;
        bit          care;
    } ctx_t;

    logic clk = 1'b0;
    logic rst;

    int errors = 0;
    int checks = 0;

    ctx_t        exp_a  [12];
    ctx_t        exp_c  [12];
    logic [15:0] vals_a [12];
    logic [15:0] vals_c [12];
    ctx_t        ctx_q  [$];
    logic [15:0] pix_q  [$];

    always #5 clk = ~clk;

    pixel_ctx_dec_if #(.DW(16)) bus ();

    pixel_ctx_dec #(
        .IMAGE_W (4),
        .IMAGE_H (3),
        .DW      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic ctx_t mk(int r, int c, int ra, int rb, int rc, int rd,
                                int d1, int d2, int d3, bit care);
        ctx_t e;
        e.row = 10'(r);  e.col = 10'(c);
        e.ra  = 16'(ra); e.rb  = 16'(rb); e.rc = 16'(rc); e.rd = 16'(rd);
        e.d1  = 17'(d1); e.d2  = 17'(d2); e.d3 = 17'(d3);
        e.care = care;
        return e;
    endfunction

    function automatic void check_ctx(string tag, ctx_t e);
        check({tag, "_row"}, 32'(bus.row), 32'(e.row));
        check({tag, "_col"}, 32'(bus.col), 32'(e.col));
        check({tag, "_Ra"},  32'(bus.Ra),  32'(e.ra));
        check({tag, "_Rb"},  32'(bus.Rb),  32'(e.rb));
        check({tag, "_Rc"},  32'(bus.Rc),  32'(e.rc));
        check({tag, "_Rd"},  32'(bus.Rd),  32'(e.rd));
        check({tag, "_D1"},  32'(bus.D1),  32'(e.d1));
        check({tag, "_D2"},  32'(bus.D2),  32'(e.d2));
        check({tag, "_D3"},  32'(bus.D3),  32'(e.d3));
    endfunction

    function automatic void check_zero(string tag);
        check({tag, "_ctx_valid"},  32'(bus.ctx_valid),  0);
        check({tag, "_RaRbRcRd"},   32'(bus.Ra | bus.Rb | bus.Rc | bus.Rd), 0);
        check({tag, "_D123"},       32'(bus.D1 | bus.D2 | bus.D3), 0);
        check({tag, "_col_row"},    32'(bus.col | bus.row), 0);
        check({tag, "_pix_out"},    32'(bus.pix_out), 0);
        check({tag, "_pix_out_en"}, 32'(bus.pix_out_en), 0);
        check({tag, "_frame_done"}, 32'(bus.frame_done), 0);
    endfunction

    // Monitor: pop and compare whenever the DUT presents a context that is
    // being accepted, or a pixel on the output stream
    always @(negedge clk) begin : monitor
        ctx_t e;
        if (!rst) begin
            if (bus.ctx_valid && bus.rx_valid) begin
                if (ctx_q.size() == 0) begin
                    check("ctx_unexpected", 1, 0);
                end else begin
                    e = ctx_q.pop_front();
                    if (e.care) check_ctx("ctx", e);
                end
            end
            if (bus.pix_out_en) begin
                if (pix_q.size() == 0) check("pix_unexpected", 1, 0);
                else                   check("pix_out", 32'(bus.pix_out), 32'(pix_q.pop_front()));
            end
        end
    end

    // Wait for a presented context, counting the bubble cycles before it
    task automatic wait_ctx(output int n);
        n = 0;
        @(negedge clk);
        while (!bus.ctx_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!bus.ctx_valid) check("ctx_timeout", 0, 1);
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("load_ctx_valid", 32'(bus.ctx_valid), 0);
        @(posedge clk); #1;
    endtask

    // Feed one frame; optionally stall at hold_k, pulse start at start_k,
    // or stop before accepting stop_k
    task automatic run_frame(input bit use_c, input int stop_k,
                             input int hold_k, input int start_k);
        ctx_t        e;
        logic [15:0] v;
        int          n;
        for (int k = 0; k < 12; k++) begin
            if (k == stop_k) begin
                bus.rx_valid = 1'b0;
                return;
            end
            e = use_c ? exp_c[k] : exp_a[k];
            v = use_c ? vals_c[k] : vals_a[k];
            if (k == hold_k) begin
                bus.rx_valid = 1'b0;
                wait_ctx(n);
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check("hold_ctx_valid", 32'(bus.ctx_valid), 1);
                    check_ctx("hold", e);
                    if (i > 0) check("hold_pix_en", 32'(bus.pix_out_en), 0);
                    @(posedge clk); #1;
                end
            end
            ctx_q.push_back(e);
            pix_q.push_back(v);
            bus.rx_data  = v;
            bus.rx_valid = 1'b1;
            if (k == start_k) bus.start = 1'b1;
            wait_ctx(n);
            if (k != hold_k) check("ctx_latency", 32'(n), (k % 4 == 0 && k != 0) ? 1 : 0);
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        // Last accept was on the preceding edge
        @(negedge clk);
        check("done_t1", 32'(bus.frame_done), 0);
        @(negedge clk);
        check("done_t2", 32'(bus.frame_done), 1);
        check("done_t2_ctx", 32'(bus.ctx_valid), 0);
        @(negedge clk);
        check("done_t3", 32'(bus.frame_done), 0);
        check("done_t3_ctx", 32'(bus.ctx_valid), 0);
        check("queues_empty", 32'(ctx_q.size() + pix_q.size()), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int n;
        // Frame A: rx = 4r + c + 1
        for (int k = 0; k < 12; k++) vals_a[k] = 16'(k + 1);
        exp_a[0]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
        exp_a[1]  = mk(0, 1,  1, 0, 0, 0, 0, 0, 'h1FFFF, 1);
        exp_a[2]  = mk(0, 2,  2, 0, 0, 0, 0, 0, 'h1FFFE, 1);
        exp_a[3]  = mk(0, 3,  3, 0, 0, 0, 0, 0, 'h1FFFD, 1);
        exp_a[4]  = mk(1, 0,  1, 1, 1, 2, 1, 0, 0, 1);
        exp_a[5]  = mk(1, 1,  5, 2, 1, 3, 1, 1, 'h1FFFC, 1);
        exp_a[6]  = mk(1, 2,  6, 3, 2, 4, 1, 1, 'h1FFFC, 1);
        exp_a[7]  = mk(1, 3,  7, 4, 3, 4, 0, 1, 'h1FFFC, 1);
        exp_a[8]  = mk(2, 0,  5, 5, 5, 6, 1, 0, 0, 1);
        exp_a[9]  = mk(2, 1,  9, 6, 5, 7, 1, 1, 'h1FFFC, 1);
        exp_a[10] = mk(2, 2, 10, 7, 6, 8, 1, 1, 'h1FFFC, 1);
        exp_a[11] = mk(2, 3, 11, 8, 7, 8, 0, 1, 'h1FFFC, 1);

        // Frame C: extreme values for gradient width
        vals_c = '{16'h0, 16'hFFFF, 16'h0, 16'h5,
                   16'h0, 16'h0,    16'h1, 16'h1,
                   16'h2, 16'h2,    16'h2, 16'h2};
        for (int k = 0; k < 12; k++) exp_c[k] = mk(k / 4, k % 4, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_c[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        exp_c[4] = mk(1, 0, 0, 0, 0, 'hFFFF, 'h0FFFF, 0, 0, 1);
        exp_c[5] = mk(1, 1, 0, 'hFFFF, 0, 0, 'h10001, 'h0FFFF, 0, 1);
        exp_c[6] = mk(1, 2, 0, 0, 'hFFFF, 5, 5, 'h10001, 'h0FFFF, 1);
        exp_c[7] = mk(1, 3, 1, 5, 0, 5, 0, 5, 'h1FFFF, 1);
        exp_c[8] = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset with start held high
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rx_valid = 1'b1;       // also ignored while idle / loading
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_after_reset", 32'(bus.ctx_valid), 0);
        check("idle_no_pix", 32'(bus.pix_out_en), 0);
        @(posedge clk); #1;

        // Frame A: stall at (1,1), mid-frame start at (0,2)
        start_frame();
        run_frame(1'b0, 99, 5, 2);

        // Frame B: reset just before accepting (2,1)
        start_frame();
        run_frame(1'b0, 9, 99, 99);
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        ctx_q.delete();
        pix_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;

        // Frame C: restart from (0,0) and gradient extremes
        start_frame();
        run_frame(1'b1, 99, 99, 99);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
